// File: rtl/ttfs_output_decoder_pkg.sv
// Shared types for the time-to-first-spike output decoder: controller states and class table entry.
package ttfs_output_decoder_pkg;

    localparam int TICK_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // One class table entry, read back as {fired, first_tick}.
    typedef struct packed {
        logic              fired;
        logic [TICK_W-1:0] first_tick;
    } entry_t;

endpackage

// File: rtl/ttfs_argmin_scan.sv
// Sequential argmin over the class table: one class per cycle while en is high, lowest index wins ties.
module ttfs_argmin_scan #(
    parameter int N_OUT = 10,
    parameter int TW    = 8,
    parameter int IW    = $clog2(N_OUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cand_fired,
    input  logic [TW-1:0] cand_tick,
    output logic [IW-1:0] idx,
    output logic          last,
    output logic [IW-1:0] best_idx_next,
    output logic          found_next
);

    logic [TW-1:0] best_tick_q;
    logic [IW-1:0] best_idx_q;
    logic          found_q;
    logic          take;

    // Strict less-than keeps the earlier (lower) index on equal ticks.
    assign take          = cand_fired && (!found_q || (cand_tick < best_tick_q));
    assign best_idx_next = take ? idx : best_idx_q;
    assign found_next    = found_q | cand_fired;
    assign last          = (idx == IW'(N_OUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            idx         <= '0;
            best_idx_q  <= '0;
            best_tick_q <= '0;
            found_q     <= 1'b0;
        end else begin
            if (!last) begin
                idx <= idx + 1'b1;
            end
            if (take) begin
                best_idx_q  <= idx;
                best_tick_q <= cand_tick;
                found_q     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttfs_output_decoder.sv
// Records the first spike tick of each output neuron and picks the earliest-firing class as the result.
//   state     | meaning
//   S_IDLE    | waiting for start_i after reset
//   S_COLLECT | recording first spike tick per output class
//   S_RESOLVE | scanning table for the earliest fired class
//   S_DONE    | decision held on winner_o until next start_i
module ttfs_output_decoder
    import ttfs_output_decoder_pkg::*;
#(
    parameter int N     = 256,
    parameter int N_OUT = 10,
    parameter int TW    = TICK_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start_i,
    input  logic [$clog2(N)-1:0]     out_base_i,
    input  logic                     early_exit_i,
    input  logic                     spike_valid_i,
    input  logic [$clog2(N)-1:0]     spike_addr_i,
    input  logic [TW-1:0]            tick_i,
    input  logic                     inference_done_i,
    input  logic [$clog2(N_OUT)-1:0] rd_idx_i,
    output logic [TW:0]              rd_data_o,
    output logic                     busy_o,
    output logic [$clog2(N_OUT)-1:0] winner_o,
    output logic                     winner_valid_o,
    output logic                     no_spike_o,
    output logic                     intr_done_o
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N_OUT);

    state_t        state_q, state_d;
    entry_t        tbl_q [N_OUT];

    logic [AW:0]   addr_x, lo_x, hi_x;
    logic          in_range;
    logic [IW-1:0] cls;
    logic          recorded;

    logic [IW-1:0] scan_idx;
    logic          scan_last;
    logic [IW-1:0] best_idx_next;
    logic          found_next;

    // Range check one bit wider than the address so base+N_OUT cannot wrap.
    assign addr_x   = {1'b0, spike_addr_i};
    assign lo_x     = {1'b0, out_base_i};
    assign hi_x     = lo_x + (AW + 1)'(N_OUT);
    assign in_range = (addr_x >= lo_x) && (addr_x < hi_x);
    assign cls      = IW'(spike_addr_i - out_base_i);
    assign recorded = (state_q == S_COLLECT) && spike_valid_i && in_range
                      && !start_i && !tbl_q[cls].fired;

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_COLLECT: if (inference_done_i || (early_exit_i && recorded)) state_d = S_RESOLVE;
                S_RESOLVE: if (scan_last) state_d = S_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || start_i) begin
            for (int i = 0; i < N_OUT; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (recorded) begin
            tbl_q[cls] <= '{fired: 1'b1, first_tick: tick_i};
        end
    end

    ttfs_argmin_scan #(
        .N_OUT (N_OUT),
        .TW    (TW),
        .IW    (IW)
    ) u_scan (
        .clk           (CLK),
        .rst           (RST),
        .en            (state_q == S_RESOLVE),
        .cand_fired    (tbl_q[scan_idx].fired),
        .cand_tick     (tbl_q[scan_idx].first_tick),
        .idx           (scan_idx),
        .last          (scan_last),
        .best_idx_next (best_idx_next),
        .found_next    (found_next)
    );

    // winner_o is left alone by start_i; only winner_valid_o says whether it is current.
    always_ff @(posedge CLK) begin
        if (RST) begin
            winner_o       <= '0;
            winner_valid_o <= 1'b0;
            no_spike_o     <= 1'b0;
            intr_done_o    <= 1'b0;
        end else begin
            intr_done_o <= 1'b0;
            if (start_i) begin
                winner_valid_o <= 1'b0;
                no_spike_o     <= 1'b0;
            end else if ((state_q == S_RESOLVE) && scan_last) begin
                winner_o       <= found_next ? best_idx_next : '0;
                no_spike_o     <= !found_next;
                winner_valid_o <= 1'b1;
                intr_done_o    <= 1'b1;
            end
        end
    end

    assign busy_o    = (state_q == S_COLLECT) || (state_q == S_RESOLVE);
    assign rd_data_o = ({1'b0, rd_idx_i} < (IW + 1)'(N_OUT)) ? tbl_q[rd_idx_i] : '0;

endmodule

// File: tb/tb_ttfs_output_decoder.sv
// Directed bench for ttfs_output_decoder: table of two-spike scenarios plus hand-written corner sequences.
module tb_ttfs_output_decoder;

    localparam int N     = 256;
    localparam int N_OUT = 10;
    localparam int TW    = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start_i;
    logic [7:0] out_base_i;
    logic       early_exit_i;
    logic       spike_valid_i;
    logic [7:0] spike_addr_i;
    logic [7:0] tick_i;
    logic       inference_done_i;
    logic [3:0] rd_idx_i;
    logic [8:0] rd_data_o;
    logic       busy_o;
    logic [3:0] winner_o;
    logic       winner_valid_o;
    logic       no_spike_o;
    logic       intr_done_o;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    ttfs_output_decoder #(.N(N), .N_OUT(N_OUT), .TW(TW)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .start_i          (start_i),
        .out_base_i       (out_base_i),
        .early_exit_i     (early_exit_i),
        .spike_valid_i    (spike_valid_i),
        .spike_addr_i     (spike_addr_i),
        .tick_i           (tick_i),
        .inference_done_i (inference_done_i),
        .rd_idx_i         (rd_idx_i),
        .rd_data_o        (rd_data_o),
        .busy_o           (busy_o),
        .winner_o         (winner_o),
        .winner_valid_o   (winner_valid_o),
        .no_spike_o       (no_spike_o),
        .intr_done_o      (intr_done_o)
    );

    typedef struct {
        logic [7:0] base;
        logic       early;
        logic       coin;
        logic [7:0] a0;
        logic [7:0] t0;
        logic       v1;
        logic [7:0] a1;
        logic [7:0] t1;
        logic [3:0] win;
        logic       nosp;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic spike(input logic [7:0] addr, input logic [7:0] t);
        spike_valid_i = 1'b1;
        spike_addr_i  = addr;
        tick_i        = t;
        cyc();
        spike_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic seen);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (intr_done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic watch_no_intr(input string name, input int cycles);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (intr_done_o) hit = 1'b1;
        end
        check(name, hit, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        vt[0] = '{8'd246, 1'b0, 1'b0, 8'd249, 8'd5, 1'b1, 8'd247, 8'd3, 4'd1, 1'b0};
        vt[1] = '{8'd246, 1'b0, 1'b0, 8'd250, 8'd4, 1'b1, 8'd248, 8'd4, 4'd2, 1'b0};
        vt[2] = '{8'd246, 1'b1, 1'b0, 8'd252, 8'd7, 1'b0, 8'd0,   8'd0, 4'd6, 1'b0};
        vt[3] = '{8'd246, 1'b0, 1'b0, 8'd10,  8'd1, 1'b0, 8'd0,   8'd0, 4'd0, 1'b1};
        vt[4] = '{8'd0,   1'b0, 1'b0, 8'd9,   8'd3, 1'b1, 8'd0,   8'd3, 4'd0, 1'b0};
        vt[5] = '{8'd250, 1'b0, 1'b0, 8'd255, 8'd6, 1'b1, 8'd3,   8'd2, 4'd5, 1'b0};
        vt[6] = '{8'd246, 1'b0, 1'b0, 8'd245, 8'd1, 1'b1, 8'd255, 8'd9, 4'd9, 1'b0};
        vt[7] = '{8'd246, 1'b0, 1'b1, 8'd249, 8'd5, 1'b1, 8'd251, 8'd2, 4'd5, 1'b0};

        RST = 1'b1; start_i = 1'b0; out_base_i = 8'd246; early_exit_i = 1'b0;
        spike_valid_i = 1'b0; spike_addr_i = '0; tick_i = '0; inference_done_i = 1'b0;
        rd_idx_i = 4'd1;
        cyc(); cyc();
        check("rst_busy",   busy_o, 1'b0);
        check("rst_winner", winner_o, 4'd0);
        check("rst_valid",  winner_valid_o, 1'b0);
        check("rst_nosp",   no_spike_o, 1'b0);
        check("rst_intr",   intr_done_o, 1'b0);
        check("rst_rd",     rd_data_o, 9'h000);
        RST = 1'b0;
        cyc();

        // Latency: intr_done N_OUT+1 cycles after the inference_done cycle.
        pulse_start();
        check("collect_busy", busy_o, 1'b1);
        spike(8'd249, 8'd5);
        spike(8'd247, 8'd3);
        inference_done_i = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            inference_done_i = 1'b0;
            n++;
            if (n == 3) check("resolve_busy", busy_o, 1'b1);
            if (intr_done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("lat_seen",   seen, 1'b1);
        check("lat_cycles", n, N_OUT + 1);
        check("lat_winner", winner_o, 4'd1);
        check("lat_valid",  winner_valid_o, 1'b1);
        check("done_busy",  busy_o, 1'b0);

        for (int k = 0; k < 8; k++) begin
            out_base_i   = vt[k].base;
            early_exit_i = vt[k].early;
            pulse_start();
            check("vec_valid_clr", winner_valid_o, 1'b0);
            spike_valid_i = 1'b1; spike_addr_i = vt[k].a0; tick_i = vt[k].t0;
            cyc();
            if (vt[k].v1) begin
                spike_addr_i = vt[k].a1; tick_i = vt[k].t1; inference_done_i = vt[k].coin;
                cyc();
            end
            spike_valid_i = 1'b0; inference_done_i = 1'b0;
            if (!vt[k].early && !vt[k].coin) begin
                inference_done_i = 1'b1;
                cyc();
                inference_done_i = 1'b0;
            end
            wait_done(n, seen);
            check($sformatf("vec%0d_intr", k),   seen, 1'b1);
            check($sformatf("vec%0d_winner", k), winner_o, vt[k].win);
            check($sformatf("vec%0d_nosp", k),   no_spike_o, vt[k].nosp);
            check($sformatf("vec%0d_valid", k),  winner_valid_o, 1'b1);
            cyc();
            check($sformatf("vec%0d_pulse", k),  intr_done_o, 1'b0);
            check($sformatf("vec%0d_hold", k),   winner_valid_o, 1'b1);
        end
        early_exit_i = 1'b0;
        out_base_i   = 8'd246;

        // Later spikes of an already-fired class are ignored.
        pulse_start();
        spike(8'd247, 8'd2);
        spike(8'd247, 8'd1);
        rd_idx_i = 4'd1;
        #1;
        check("rd_first_tick", rd_data_o, 9'h102);
        rd_idx_i = 4'd0;
        #1;
        check("rd_unfired", rd_data_o, 9'h000);

        // Reset in the middle of the scan.
        inference_done_i = 1'b1;
        cyc();
        inference_done_i = 1'b0;
        cyc(); cyc(); cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        rd_idx_i = 4'd1;
        #1;
        check("mrst_busy",   busy_o, 1'b0);
        check("mrst_winner", winner_o, 4'd0);
        check("mrst_valid",  winner_valid_o, 1'b0);
        check("mrst_nosp",   no_spike_o, 1'b0);
        check("mrst_intr",   intr_done_o, 1'b0);
        check("mrst_table",  rd_data_o, 9'h000);
        spike_valid_i = 1'b1; spike_addr_i = 8'd247; tick_i = 8'd4; inference_done_i = 1'b1;
        cyc();
        spike_valid_i = 1'b0; inference_done_i = 1'b0;
        check("idle_ignore", rd_data_o, 9'h000);
        check("idle_busy",   busy_o, 1'b0);
        watch_no_intr("mrst_no_intr", 15);

        // start_i coinciding with a spike drops that spike.
        pulse_start();
        start_i = 1'b1;
        spike(8'd247, 8'd3);
        start_i = 1'b0;
        spike(8'd248, 8'd4);
        rd_idx_i = 4'd1;
        #1;
        check("start_spike_drop", rd_data_o, 9'h000);
        rd_idx_i = 4'd2;
        #1;
        check("start_spike_next", rd_data_o, 9'h104);
        inference_done_i = 1'b1;
        cyc();
        inference_done_i = 1'b0;
        wait_done(n, seen);
        check("start_intr",   seen, 1'b1);
        check("start_winner", winner_o, 4'd2);

        // Spikes and inference_done in DONE change nothing.
        spike_valid_i = 1'b1; spike_addr_i = 8'd249; tick_i = 8'd1; inference_done_i = 1'b1;
        cyc();
        spike_valid_i = 1'b0; inference_done_i = 1'b0;
        rd_idx_i = 4'd3;
        #1;
        check("done_ignore", rd_data_o, 9'h000);
        watch_no_intr("done_no_intr", 15);
        check("done_hold_valid",  winner_valid_o, 1'b1);
        check("done_hold_winner", winner_o, 4'd2);
        pulse_start();
        rd_idx_i = 4'd2;
        #1;
        check("restart_valid", winner_valid_o, 1'b0);
        check("restart_nosp",  no_spike_o, 1'b0);
        check("restart_busy",  busy_o, 1'b1);
        check("restart_table", rd_data_o, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ttfs_output_decoder.md
TTFS_OUTPUT_DECODER -- requirements
Module: ttfs_output_decoder

Interface
REQ-001 SHALL have parameter N, default 256: neuron count; address width AW = clog2(N).
REQ-002 SHALL have parameter N_OUT, default 10: number of output (class) neurons decoded.
REQ-003 SHALL have parameter TW, default 8: tick width, matching the tick generator's tick.
REQ-004 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start_i  in  1  one-cycle pulse that clears the table and arms collection.
REQ-007 SHALL have port out_base_i  in  AW  index of the first output neuron; outputs are out_base_i .. out_base_i+N_OUT-1.
REQ-008 SHALL have port early_exit_i  in  1  when 1, the first valid output spike decides the result.
REQ-009 SHALL have port spike_valid_i  in  1  a neuron spiked this cycle (neuron core spike flag).
REQ-010 SHALL have port spike_addr_i  in  AW  index of the spiking neuron.
REQ-011 SHALL have port tick_i  in  TW  current time step.
REQ-012 SHALL have port inference_done_i  in  1  inference finished (tick limit reached).
REQ-013 SHALL have port rd_idx_i  in  clog2(N_OUT)  class index for table readback.
REQ-014 SHALL have port rd_data_o  out  TW+1  {fired, first_tick} of class rd_idx_i, combinational read.
REQ-015 SHALL have port busy_o  out  1  high in COLLECT and RESOLVE.
REQ-016 SHALL have port winner_o  out  clog2(N_OUT)  decided class.
REQ-017 SHALL have port winner_valid_o  out  1  winner_o is meaningful; held until next start_i.
REQ-018 SHALL have port no_spike_o  out  1  decision made with no output neuron fired.
REQ-019 SHALL have port intr_done_o  out  1  one-cycle pulse when the decision is made.

Function
REQ-020 SHALL implement FSM IDLE -> COLLECT (start_i) -> RESOLVE (inference_done_i, or a recorded spike with early_exit_i=1) -> DONE -> COLLECT (start_i); start_i in any state forces COLLECT with the table cleared.
REQ-021 SHALL, in COLLECT only, treat a spike as an output spike when out_base_i <= spike_addr_i < out_base_i+N_OUT, with the compare evaluated at AW+1 bits so that no wrap-around occurs.
REQ-022 SHALL record first_tick=tick_i and fired=1 for class (spike_addr_i - out_base_i) only if that class has not fired; later spikes of the same class SHALL be ignored.
REQ-023 SHALL, when spike_valid_i and inference_done_i coincide in COLLECT, record the spike first and then enter RESOLVE.
REQ-024 SHALL, in RESOLVE, scan classes 0..N_OUT-1 one per cycle (N_OUT cycles) and keep the fired class with the minimum first_tick; on a tie the lower index wins.
REQ-025 SHALL, after the scan, enter DONE, set winner_valid_o=1 and pulse intr_done_o for exactly one cycle.
REQ-026 SHALL, when no class fired, set winner_o=0, no_spike_o=1 and winner_valid_o=1.
REQ-027 SHALL ignore spikes and inference_done_i in IDLE, RESOLVE and DONE.
REQ-028 SHALL clear winner_valid_o and no_spike_o on start_i; start_i asserted in the same cycle as a spike SHALL clear the table, and the spike SHALL NOT be recorded.

Reset
REQ-029 SHALL, on RST=1 at a clock edge, enter IDLE and clear all fired flags and first_tick entries to 0; busy_o, winner_o, winner_valid_o, no_spike_o and intr_done_o SHALL all be 0.
REQ-030 SHALL give RST priority over start_i; RST during RESOLVE SHALL abort the scan with no intr_done_o.

Structure
REQ-031 SHALL place the FSM state enum and the {fired, first_tick} entry typedef in the shared tinyODIN package.
REQ-032 SHALL implement the class table as a flop array inside the module; the argmin scan MAY be a sub-module named ttfs_argmin_scan.

Verification
REQ-033 SHALL verify: out_base=246; spikes 249@t5, 247@t3 -> winner=1, winner_valid, intr_done pulse 1 cycle, N_OUT+1 cycles after inference_done_i.
REQ-034 SHALL verify: spikes 250@t4, 248@t4 -> winner=2 (tie resolved to the lower index).
REQ-035 SHALL verify: 247@t2, then 247@t1 -> rd_idx=1 reads {1, 2}.
REQ-036 SHALL verify: early_exit=1, spike 252@t7 -> RESOLVE without inference_done_i, winner=6.
REQ-037 SHALL verify: no output spikes, a non-output spike addr 10, inference_done -> no_spike_o=1, winner=0.
REQ-038 SHALL verify: RST mid-RESOLVE -> IDLE, all outputs 0, no intr; start_i coincident with a spike -> that spike is not recorded.
